bel_cmul_pipe: RTL and testbench
================================

Name: bel_cmul_pipe

Overview:
Parametrised, fully pipelined signed complex multiplier, x = a*b or x = a*conj(b), with a valid/ready handshake. It replaces the fixed-width, halt-driven multiplier in the bel_fft butterfly and twiddle datapath. Input, twiddle and output widths are configurable, as are rounding and saturation. It reports overflow per result and as a sticky flag, and carries a sideband tag through the pipeline alongside the data.

Parameters:
A_WIDTH, 16, signed width of a_re_i/a_im_i
B_WIDTH, 16, signed width of b_re_i/b_im_i (twiddle, Q1.(B_WIDTH-1))
OUT_WIDTH, 16, signed width of x_re_o/x_im_o
FRAC_BITS, B_WIDTH-1, arithmetic right shift applied after accumulation (0 allowed)
ROUND, 1, 1 = round half up (add 2^(FRAC_BITS-1) before shift); 0 = truncate toward -inf
SATURATE, 1, 1 = clamp to OUT_WIDTH signed range; 0 = wrap (keep LSBs)
TAG_WIDTH, 8, width of sideband tag carried with each sample (>=1)

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
in_valid_i  in  1  input sample valid
in_ready_o  out  1  block accepts input this cycle
conj_i  in  1  1 = multiply by conj(b); sampled with input
a_re_i, a_im_i  in  A_WIDTH  operand a (signed)
b_re_i, b_im_i  in  B_WIDTH  operand b (signed)
tag_i  in  TAG_WIDTH  sideband tag
out_valid_o  out  1  result valid
out_ready_i  in  1  downstream accepts result
x_re_o, x_im_o  out  OUT_WIDTH  result (signed)
tag_o  out  TAG_WIDTH  tag aligned to result
ovf_o  out  1  current result clipped (SATURATE=1) or wrapped (SATURATE=0)
ovf_sticky_o  out  1  set by any accepted overflowing result; cleared by ovf_clr_i
ovf_clr_i  in  1  synchronous clear of ovf_sticky_o

Behaviour:
- Reset (rst_n_i low, asynchronous): all valid bits, data/tag registers, ovf_o and ovf_sticky_o go to 0. in_ready_o = 1 immediately after reset. Reset mid-operation discards all in-flight samples.
- Pipeline enable: en = ~out_valid_o | out_ready_i. in_ready_o = en (combinational).
- All stages advance together when en = 1 and hold when en = 0. Bubbles are not compressed. Input transfer occurs when in_valid_i & in_ready_o.
- Stage 1 (registered): four products ar*br, ar*bi, ai*br, ai*bi, each A_WIDTH+B_WIDTH bits signed. conj, tag and valid are registered alongside.
- Stage 2: sums are A_WIDTH+B_WIDTH+1 bits, so there is no internal overflow.
  - conj=0: re = ar*br - ai*bi, im = ar*bi + ai*br.
  - conj=1: re = ar*br + ai*bi, im = ai*br - ar*bi.
- Stage 3: round (if ROUND and FRAC_BITS>0), then arithmetic shift right by FRAC_BITS, then saturate or wrap to OUT_WIDTH. ovf_o = 1 if the shifted value lies outside [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] for either component.
- Latency: 3 cycles from input transfer to out_valid_o with no stall. Throughput is 1 sample per cycle.
- Output stability: while out_valid_o & ~out_ready_i, outputs, tag_o and ovf_o are held stable.
- ovf_sticky_o: set on the cycle an output with ovf_o=1 transfers. ovf_clr_i clears it. If clear and set occur in the same cycle, set wins.
- Valid-bit gating: tag_o and ovf_o are meaningful only with out_valid_o.

Decomposition:
- The bel_fft_def.v include gains default-width and rounding/saturation mode defines (BEL_CMUL_ROUND_HALF_UP, BEL_CMUL_TRUNC).
- One sub-module, bel_round_sat (parametrised IN_WIDTH, OUT_WIDTH, FRAC_BITS, ROUND, SATURATE), is purely combinational: round/shift/clip plus ovf flag. It is instantiated twice in stage 3 and is reused by the FFT output scaler.

Test Plan:
1. Defaults, conj=0, a=(0x4000,0), b=(0x4000,0), out_ready_i=1 -> after 3 cycles x=(0x2000,0x0000), ovf_o=0, tag_o equals tag_i.
2. Conjugate mode:
   - a=(0,0x4000), b=(0,0x4000), conj=0 -> x=(0xE000,0).
   - Same operands with conj=1 -> x=(0x2000,0).
3. Overflow:
   - a=(-32768,0), b=(-32768,0), SATURATE=1 -> x_re=0x7FFF, ovf_o=1, ovf_sticky_o=1 until ovf_clr_i pulse.
   - SATURATE=0 -> x_re=0x8000, ovf_o=1.
4. Rounding:
   - a=(1,0), b=(0x4000,0): ROUND=1 -> x_re=1; ROUND=0 -> x_re=0.
   - a=(-1,0), same b: ROUND=1 -> x_re=0; ROUND=0 -> x_re=0xFFFF.
5. Backpressure: stream 8 samples with tags 0..7, with out_ready_i low for 4 cycles mid-stream -> in_ready_o low while stalled, outputs held stable, all 8 results delivered in order with no loss or duplication.
6. Reset: assert rst_n_i low asynchronously with 3 samples in flight -> out_valid_o=0 and ovf_sticky_o=0 immediately, and no stale results appear after release. Repeat test 1 with A_WIDTH=18, B_WIDTH=12, OUT_WIDTH=20.

Source files
------------

// File: rtl/bel_cmul_pkg.sv
// Shared defaults and mode encodings for the bel_cmul complex multiplier and its
// round/saturate stage. The FFT output scaler reuses the same encodings.
package bel_cmul_pkg;

    localparam int CMUL_A_WIDTH_DEF   = 16;
    localparam int CMUL_B_WIDTH_DEF   = 16;
    localparam int CMUL_OUT_WIDTH_DEF = 16;
    localparam int CMUL_TAG_WIDTH_DEF = 8;

    // Rounding and overflow-handling modes.
    localparam int CMUL_ROUND_HALF_UP = 1;
    localparam int CMUL_TRUNC         = 0;
    localparam int CMUL_SAT_CLAMP     = 1;
    localparam int CMUL_SAT_WRAP      = 0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bel_round_sat.sv
// Combinational round-half-up (or truncate), arithmetic shift right by FRAC_BITS,
// then clamp or wrap to OUT_WIDTH with an out-of-range flag.
module bel_round_sat
    import bel_cmul_pkg::*;
#(
    parameter int IN_WIDTH  = 33,
    parameter int OUT_WIDTH = 16,
    parameter int FRAC_BITS = 15,
    parameter int ROUND     = CMUL_ROUND_HALF_UP,
    parameter int SATURATE  = CMUL_SAT_CLAMP
) (
    input  logic signed [IN_WIDTH-1:0]  val_i,
    output logic signed [OUT_WIDTH-1:0] val_o,
    output logic                        ovf_o
);

    // One guard bit above the input so adding the rounding constant cannot wrap.
    localparam int W      = max_int(IN_WIDTH + 1, OUT_WIDTH + 1);
    localparam int RND_SH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;

    localparam logic signed [W-1:0] RND_ADD = (ROUND != 0 && FRAC_BITS > 0)
                                            ? ({{(W-1){1'b0}}, 1'b1} << RND_SH) : '0;
    localparam logic signed [W-1:0] MAX_V = {{(W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_V = {{(W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic signed [W-1:0] shifted;
    logic                above;
    logic                below;

    // NOTE: every output of this always_comb gets a value before any branch, so no latch is inferred.
    always_comb begin
        shifted = (W'(val_i) + RND_ADD) >>> FRAC_BITS;
        above   = shifted > MAX_V;
        below   = shifted < MIN_V;
        ovf_o   = above | below;
        val_o   = shifted[OUT_WIDTH-1:0];
        if (SATURATE != 0) begin
            if (above)      val_o = MAX_V[OUT_WIDTH-1:0];
            else if (below) val_o = MIN_V[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/bel_cmul_pipe.sv
// Three-stage signed complex multiplier x = a*b or a*conj(b) with valid/ready flow
// control, sideband tag, per-result overflow and a sticky overflow flag.
module bel_cmul_pipe
    import bel_cmul_pkg::*;
#(
    parameter int A_WIDTH   = CMUL_A_WIDTH_DEF,
    parameter int B_WIDTH   = CMUL_B_WIDTH_DEF,
    parameter int OUT_WIDTH = CMUL_OUT_WIDTH_DEF,
    parameter int FRAC_BITS = B_WIDTH - 1,
    parameter int ROUND     = CMUL_ROUND_HALF_UP,
    parameter int SATURATE  = CMUL_SAT_CLAMP,
    parameter int TAG_WIDTH = CMUL_TAG_WIDTH_DEF
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic                        conj_i,
    input  logic signed [A_WIDTH-1:0]   a_re_i,
    input  logic signed [A_WIDTH-1:0]   a_im_i,
    input  logic signed [B_WIDTH-1:0]   b_re_i,
    input  logic signed [B_WIDTH-1:0]   b_im_i,
    input  logic [TAG_WIDTH-1:0]        tag_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic signed [OUT_WIDTH-1:0] x_re_o,
    output logic signed [OUT_WIDTH-1:0] x_im_o,
    output logic [TAG_WIDTH-1:0]        tag_o,
    output logic                        ovf_o,
    output logic                        ovf_sticky_o,
    input  logic                        ovf_clr_i
);

    localparam int PW = A_WIDTH + B_WIDTH;
    localparam int SW = PW + 1;

    logic en;

    logic                 s1_valid_q, s1_conj_q;
    logic [TAG_WIDTH-1:0] s1_tag_q;
    logic signed [PW-1:0] s1_rr_q, s1_ri_q, s1_ir_q, s1_ii_q;

    logic                 s2_valid_q;
    logic [TAG_WIDTH-1:0] s2_tag_q;
    logic signed [SW-1:0] s2_re_q, s2_im_q, s2_re_d, s2_im_d;

    logic                        s3_valid_q, ovf_q, ovf_sticky_q, ovf_sticky_d;
    logic [TAG_WIDTH-1:0]        s3_tag_q;
    logic signed [OUT_WIDTH-1:0] x_re_q, x_im_q, x_re_d, x_im_d;
    logic                        ovf_re, ovf_im;

    // The whole pipe moves in lockstep; a held output freezes every stage, bubbles included.
    assign en         = ~s3_valid_q | out_ready_i;
    assign in_ready_o = en;

    // Sums carry one bit more than the products, so no internal overflow is possible.
    always_comb begin
        s2_re_d = SW'(s1_rr_q) - SW'(s1_ii_q);
        s2_im_d = SW'(s1_ri_q) + SW'(s1_ir_q);
        if (s1_conj_q) begin
            s2_re_d = SW'(s1_rr_q) + SW'(s1_ii_q);
            s2_im_d = SW'(s1_ir_q) - SW'(s1_ri_q);
        end
    end

    bel_round_sat #(
        .IN_WIDTH (SW), .OUT_WIDTH(OUT_WIDTH), .FRAC_BITS(FRAC_BITS),
        .ROUND    (ROUND), .SATURATE(SATURATE)
    ) u_rs_re (
        .val_i(s2_re_q), .val_o(x_re_d), .ovf_o(ovf_re)
    );

    bel_round_sat #(
        .IN_WIDTH (SW), .OUT_WIDTH(OUT_WIDTH), .FRAC_BITS(FRAC_BITS),
        .ROUND    (ROUND), .SATURATE(SATURATE)
    ) u_rs_im (
        .val_i(s2_im_q), .val_o(x_im_d), .ovf_o(ovf_im)
    );

    // Set wins over clear when an overflowing result leaves in the same cycle.
    assign ovf_sticky_d = (ovf_sticky_q & ~ovf_clr_i) | (s3_valid_q & out_ready_i & ovf_q);

    // NOTE: data registers are reset as well as valids, so nothing X ever reaches the ports.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid_q   <= 1'b0;
            s1_conj_q    <= 1'b0;
            s1_tag_q     <= '0;
            s1_rr_q      <= '0;
            s1_ri_q      <= '0;
            s1_ir_q      <= '0;
            s1_ii_q      <= '0;
            s2_valid_q   <= 1'b0;
            s2_tag_q     <= '0;
            s2_re_q      <= '0;
            s2_im_q      <= '0;
            s3_valid_q   <= 1'b0;
            s3_tag_q     <= '0;
            x_re_q       <= '0;
            x_im_q       <= '0;
            ovf_q        <= 1'b0;
            ovf_sticky_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every stage samples the previous stage's old value.
            ovf_sticky_q <= ovf_sticky_d;
            if (en) begin
                s1_valid_q <= in_valid_i;
                s1_conj_q  <= conj_i;
                s1_tag_q   <= tag_i;
                s1_rr_q    <= PW'(a_re_i) * PW'(b_re_i);
                s1_ri_q    <= PW'(a_re_i) * PW'(b_im_i);
                s1_ir_q    <= PW'(a_im_i) * PW'(b_re_i);
                s1_ii_q    <= PW'(a_im_i) * PW'(b_im_i);
                s2_valid_q <= s1_valid_q;
                s2_tag_q   <= s1_tag_q;
                s2_re_q    <= s2_re_d;
                s2_im_q    <= s2_im_d;
                s3_valid_q <= s2_valid_q;
                s3_tag_q   <= s2_tag_q;
                x_re_q     <= x_re_d;
                x_im_q     <= x_im_d;
                ovf_q      <= ovf_re | ovf_im;
            end
        end
    end

    assign out_valid_o  = s3_valid_q;
    assign x_re_o       = x_re_q;
    assign x_im_o       = x_im_q;
    assign tag_o        = s3_tag_q;
    assign ovf_o        = ovf_q;
    assign ovf_sticky_o = ovf_sticky_q;

endmodule

// File: tb/tb_bel_cmul_pipe.sv
// Directed bench for bel_cmul_pipe: default, truncate/wrap and wide-width instances
// driven in lockstep, with hand-computed expected results.
module tb_bel_cmul_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid, conj, out_ready, ovf_clr;
    logic [15:0] a_re, a_im, b_re, b_im;
    logic [17:0] wa_re, wa_im;
    logic [11:0] wb_re, wb_im;
    logic [7:0]  tag;

    logic        d_in_ready, d_out_valid, d_ovf, d_sticky;
    logic [15:0] d_x_re, d_x_im;
    logic [7:0]  d_tag;

    logic        w_in_ready, w_out_valid, w_ovf, w_sticky;
    logic [15:0] w_x_re, w_x_im;
    logic [7:0]  w_tag;

    logic        g_in_ready, g_out_valid, g_ovf, g_sticky;
    logic [19:0] g_x_re, g_x_im;
    logic [7:0]  g_tag;

    int n_checks = 0;
    int n_fails  = 0;

    bel_cmul_pipe u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(d_in_ready),
        .conj_i(conj), .a_re_i(a_re), .a_im_i(a_im), .b_re_i(b_re), .b_im_i(b_im),
        .tag_i(tag), .out_valid_o(d_out_valid), .out_ready_i(out_ready),
        .x_re_o(d_x_re), .x_im_o(d_x_im), .tag_o(d_tag), .ovf_o(d_ovf),
        .ovf_sticky_o(d_sticky), .ovf_clr_i(ovf_clr)
    );

    bel_cmul_pipe #(.ROUND(0), .SATURATE(0)) u_wrap (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(w_in_ready),
        .conj_i(conj), .a_re_i(a_re), .a_im_i(a_im), .b_re_i(b_re), .b_im_i(b_im),
        .tag_i(tag), .out_valid_o(w_out_valid), .out_ready_i(out_ready),
        .x_re_o(w_x_re), .x_im_o(w_x_im), .tag_o(w_tag), .ovf_o(w_ovf),
        .ovf_sticky_o(w_sticky), .ovf_clr_i(ovf_clr)
    );

    bel_cmul_pipe #(.A_WIDTH(18), .B_WIDTH(12), .OUT_WIDTH(20)) u_wide (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(g_in_ready),
        .conj_i(conj), .a_re_i(wa_re), .a_im_i(wa_im), .b_re_i(wb_re), .b_im_i(wb_im),
        .tag_i(tag), .out_valid_o(g_out_valid), .out_ready_i(out_ready),
        .x_re_o(g_x_re), .x_im_o(g_x_im), .tag_o(g_tag), .ovf_o(g_ovf),
        .ovf_sticky_o(g_sticky), .ovf_clr_i(ovf_clr)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // One-cycle input transfer; returns #1 after the capture edge.
    task automatic send(input logic c, input logic [15:0] ar, input logic [15:0] ai,
                        input logic [15:0] br, input logic [15:0] bi, input logic [7:0] t);
        conj = c; a_re = ar; a_im = ai; b_re = br; b_im = bi; tag = t;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Returns #1 after the edge on which a just-sent sample reaches the output.
    task automatic to_output();
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Scoreboard capture and hold-stability monitor, sampled on the falling edge.
    logic [7:0]  rx_tag[$];
    logic [15:0] rx_re[$];
    logic        mon_en = 1'b0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_re, prev_im;
    logic [7:0]  prev_tag;
    logic        prev_ovf;

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall && d_out_valid) begin
                check("hold_x_re", d_x_re, prev_re);
                check("hold_x_im", d_x_im, prev_im);
                check("hold_tag",  d_tag,  prev_tag);
                check("hold_ovf",  d_ovf,  prev_ovf);
            end
            if (mon_en && d_out_valid && out_ready) begin
                rx_tag.push_back(d_tag);
                rx_re.push_back(d_x_re);
            end
            prev_stall = d_out_valid & ~out_ready;
            prev_re = d_x_re; prev_im = d_x_im; prev_tag = d_tag; prev_ovf = d_ovf;
        end else begin
            prev_stall = 1'b0;
        end
    end

    int   idx, cyc, stale;
    logic accepted;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; conj = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
        a_re = '0; a_im = '0; b_re = '0; b_im = '0; tag = '0;
        wa_re = '0; wa_im = '0; wb_re = '0; wb_im = '0;

        #12;
        check("rst_out_valid", d_out_valid, 0);
        check("rst_in_ready",  d_in_ready,  1);
        check("rst_sticky",    d_sticky,    0);
        check("rst_ovf",       d_ovf,       0);
        check("rst_x_re",      d_x_re,      0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic product with exact three-cycle latency; wide instance uses b = 0.5 in Q1.11.
        wa_re = 18'h04000; wb_re = 12'h400;
        send(1'b0, 16'h4000, 16'h0000, 16'h4000, 16'h0000, 8'hA5);
        @(posedge clk); #1;
        check("lat_not_early", d_out_valid, 0);
        @(posedge clk); #1;
        check("t1_valid", d_out_valid, 1);
        check("t1_x_re",  d_x_re, 16'h2000);
        check("t1_x_im",  d_x_im, 16'h0000);
        check("t1_ovf",   d_ovf,  0);
        check("t1_tag",   d_tag,  8'hA5);
        check("wide_valid", g_out_valid, 1);
        check("wide_x_re",  g_x_re, 20'h02000);
        check("wide_x_im",  g_x_im, 20'h00000);
        check("wide_tag",   g_tag,  8'hA5);

        // j*0.5 times j*0.5, plain and conjugated.
        send(1'b0, 16'h0000, 16'h4000, 16'h0000, 16'h4000, 8'h11);
        to_output();
        check("conj0_x_re", d_x_re, 16'hE000);
        check("conj0_x_im", d_x_im, 16'h0000);
        send(1'b1, 16'h0000, 16'h4000, 16'h0000, 16'h4000, 8'h12);
        to_output();
        check("conj1_x_re", d_x_re, 16'h2000);
        check("conj1_x_im", d_x_im, 16'h0000);
        check("conj1_tag",  d_tag,  8'h12);

        // (-1)*(-1) = +1 is out of range: clamp in default, wrap in u_wrap.
        send(1'b0, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 8'h20);
        to_output();
        check("sat_x_re",  d_x_re, 16'h7FFF);
        check("sat_ovf",   d_ovf,  1);
        check("wrap_x_re", w_x_re, 16'h8000);
        check("wrap_ovf",  w_ovf,  1);
        check("sticky_pre_xfer", d_sticky, 0);
        repeat (4) @(posedge clk);
        #1;
        check("sticky_holds", d_sticky, 1);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        check("sticky_cleared", d_sticky, 0);

        // Half-LSB boundaries: round half up versus truncate toward -inf.
        send(1'b0, 16'h0001, 16'h0000, 16'h4000, 16'h0000, 8'h30);
        to_output();
        check("rnd_pos_round", d_x_re, 16'h0001);
        check("rnd_pos_trunc", w_x_re, 16'h0000);
        check("rnd_pos_ovf",   d_ovf,  0);
        send(1'b0, 16'hFFFF, 16'h0000, 16'h4000, 16'h0000, 8'h31);
        to_output();
        check("rnd_neg_round", d_x_re, 16'h0000);
        check("rnd_neg_trunc", w_x_re, 16'hFFFF);

        // Wide instance near full scale: 131071*2047 = 268302337, +1024 then >>11 = 131007.
        wa_re = 18'h1FFFF; wb_re = 12'h7FF;
        send(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'h40);
        to_output();
        check("wide_big_x_re", g_x_re, 20'h1FFBF);
        check("wide_big_ovf",  g_ovf,  0);
        wa_re = '0; wb_re = '0;

        // Clear and set in the same cycle: set wins.
        send(1'b0, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 8'h50);
        to_output();
        check("clrset_pre", d_sticky, 0);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        check("clrset_set_wins", d_sticky, 1);

        // Eight-sample stream with a four-cycle output stall.
        mon_en = 1'b1; idx = 0; cyc = 0;
        while ((idx < 8 || rx_tag.size() < 8) && cyc < 60) begin
            in_valid  = (idx < 8);
            conj      = 1'b0;
            a_re      = 16'(idx * 16'h0800); a_im = '0;
            b_re      = 16'h4000;            b_im = '0;
            tag       = 8'(idx);
            out_ready = !(cyc >= 4 && cyc < 8);
            @(negedge clk);
            accepted = in_valid && d_in_ready;
            if (!out_ready && d_out_valid)
                check("stall_in_ready", d_in_ready, 0);
            @(posedge clk); #1;
            if (accepted) idx++;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk) mon_en = 1'b0;
        check("stream_timeout", (cyc < 60), 1);
        check("stream_count", rx_tag.size(), 8);
        for (int i = 0; i < 8 && i < rx_tag.size(); i++) begin
            check("stream_tag",  rx_tag[i], i);
            check("stream_x_re", rx_re[i],  i * 32'h0400);
        end

        // Asynchronous reset with three samples in flight; sticky is still set from above.
        @(posedge clk); #1;
        check("pre_rst_sticky", d_sticky, 1);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tag = 8'(8'h60 + i); a_re = 16'h2000; b_re = 16'h4000;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("pre_rst_valid", d_out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid",    d_out_valid, 0);
        check("async_rst_sticky",   d_sticky,    0);
        check("async_rst_in_ready", d_in_ready,  1);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (d_out_valid) stale++;
        end
        check("no_stale_after_rst", stale, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
